fpnew_noncomp_wb: RTL

Writeback buffer for the non-computational FP unit. It sits directly downstream of the noncomp slice and accepts that slice's result, status, extension bit, class mask, is-class flag and tag. It formats each entry into a FLEN-wide register-file word, with NaN-boxing or sign-extension for floats and zero-extension for class masks. Entries are held in a small FIFO until the core's writeback port accepts them, and a sticky fflags accumulator can optionally be compiled in.

---
 rtl/fpnew_pkg.sv | 70 +++++++
 rtl/fpnew_noncomp_wb_fifo.sv | 70 +++++++
 rtl/fpnew_noncomp_wb.sv | 103 ++++++++++
 3 files changed

// File: rtl/fpnew_pkg.sv
// Shared FP types plus the writeback word formatter used by the noncomp writeback buffer.
// Only the subset of fpnew_pkg this slice needs is declared here.
package fpnew_pkg;

   typedef enum logic [2:0] {
      FP32    = 3'd0,
      FP64    = 3'd1,
      FP16    = 3'd2,
      FP8     = 3'd3,
      FP16ALT = 3'd4
   } fp_format_e;

   localparam int unsigned CLASS_MASK_BITS = 10;
   localparam int unsigned MAX_WB_WIDTH    = 128;

   typedef struct packed {
      logic NV;
      logic DZ;
      logic OF;
      logic UF;
      logic NX;
   } status_t;

   typedef enum logic [CLASS_MASK_BITS-1:0] {
      NEGINF     = 10'b00_0000_0001,
      NEGNORM    = 10'b00_0000_0010,
      NEGSUBNORM = 10'b00_0000_0100,
      NEGZERO    = 10'b00_0000_1000,
      POSZERO    = 10'b00_0001_0000,
      POSSUBNORM = 10'b00_0010_0000,
      POSNORM    = 10'b00_0100_0000,
      POSINF     = 10'b00_1000_0000,
      SNAN       = 10'b01_0000_0000,
      QNAN       = 10'b10_0000_0000
   } classmask_e;

   function automatic int unsigned fp_width(input fp_format_e fmt);
      int unsigned w;
      unique case (fmt)
         FP64:    w = 64;
         FP16:    w = 16;
         FP8:     w = 8;
         FP16ALT: w = 16;
         default: w = 32;
      endcase
      return w;
   endfunction

   // Class masks are zero-extended; float results are filled with ext above bit width-1.
   // Everything from bit flen upward is cleared so the caller can truncate freely.
   function automatic logic [MAX_WB_WIDTH-1:0] fmt_wb_word(
      input logic [MAX_WB_WIDTH-1:0] result,
      input logic                    ext,
      input classmask_e              mask,
      input logic                    is_class,
      input int unsigned             width,
      input int unsigned             flen
   );
      logic [MAX_WB_WIDTH-1:0] low_mask;
      logic [MAX_WB_WIDTH-1:0] word;
      low_mask = ~({MAX_WB_WIDTH{1'b1}} << width);
      if (is_class) begin
         word = MAX_WB_WIDTH'(mask);
      end else begin
         word = (result & low_mask) | ({MAX_WB_WIDTH{ext}} & ~low_mask);
      end
      return word & ~({MAX_WB_WIDTH{1'b1}} << flen);
   endfunction

endpackage

// File: rtl/fpnew_noncomp_wb_fifo.sv
// Generic Depth-entry FIFO with count/full/empty, synchronous active-low reset and flush.
// Storage is not reset; only pointers and count are.
module fpnew_noncomp_wb_fifo #(
   parameter  int unsigned Depth   = 2,
   parameter  type         dtype_t = logic,
   localparam int unsigned AddrW   = $clog2(Depth),
   localparam int unsigned CntW    = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            push_i,
   input  dtype_t          data_i,
   input  logic            pop_i,
   output dtype_t          data_o,
   output logic [CntW-1:0] count_o,
   output logic            full_o,
   output logic            empty_o
);

   dtype_t            mem_q [Depth];
   logic [AddrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AddrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]   count_q, count_d;
   logic              push_ok, pop_ok;

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i & ~full_o & ~flush_i;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
         if (pop_ok)  rd_ptr_d = rd_ptr_q + AddrW'(1);
         unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fpnew_noncomp_wb.sv
// Writeback buffer for the noncomp FP slice: formats results at push time and queues them.
// Define FPNEW_NONCOMP_WB_FFLAGS_EN to add the sticky fflags accumulator and its ports.
module fpnew_noncomp_wb
   import fpnew_pkg::*;
#(
   parameter  fp_format_e  FpFormat = FP32,
   parameter  int unsigned Flen     = 64,
   parameter  int unsigned Depth    = 2,
   parameter  type         TagType  = logic,
   localparam int unsigned WIDTH    = fp_width(FpFormat)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] result_i,
   input  status_t          status_i,
   input  logic             extension_bit_i,
   input  classmask_e       class_mask_i,
   input  logic             is_class_i,
   input  TagType           tag_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic             flush_i,
   output logic [Flen-1:0]  result_o,
   output status_t          status_o,
   output TagType           tag_o,
   output logic             out_valid_o,
   input  logic             out_ready_i,
`ifdef FPNEW_NONCOMP_WB_FFLAGS_EN
   input  logic             fflags_clr_i,
   output logic [4:0]       fflags_o,
`endif
   output logic             busy_o
);

   localparam int unsigned CntW = $clog2(Depth + 1);

   typedef struct packed {
      logic [Flen-1:0] word;
      status_t         status;
      TagType          tag;
   } entry_t;

   entry_t          push_entry;
   entry_t          head_entry;
   logic            push;
   logic            pop;
   logic            full;
   logic            empty;
   logic [CntW-1:0] count;

   always_comb begin
      push_entry        = '0;
      push_entry.word   = Flen'(fmt_wb_word(MAX_WB_WIDTH'(result_i), extension_bit_i,
                                            class_mask_i, is_class_i, WIDTH, Flen));
      push_entry.status = status_i;
      push_entry.tag    = tag_i;
   end

   assign in_ready_o  = ~full;
   assign out_valid_o = ~empty;
   assign push        = in_valid_i & in_ready_o;
   assign pop         = out_valid_o & out_ready_i;

   fpnew_noncomp_wb_fifo #(
      .Depth   (Depth),
      .dtype_t (entry_t)
   ) i_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (head_entry),
      .count_o (count),
      .full_o  (full),
      .empty_o (empty)
   );

   assign result_o = head_entry.word;
   assign status_o = head_entry.status;
   assign tag_o    = head_entry.tag;
   assign busy_o   = (count != '0);

`ifdef FPNEW_NONCOMP_WB_FFLAGS_EN
   logic [4:0] fflags_q, fflags_d;

   // Clear takes effect before the popped status is ORed in.
   always_comb begin
      fflags_d = fflags_q;
      if (fflags_clr_i) fflags_d = '0;
      if (pop)          fflags_d = fflags_d | head_entry.status;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) fflags_q <= '0;
      else         fflags_q <= fflags_d;
   end

   assign fflags_o = fflags_q;
`endif

endmodule
